// File: rtl/serial_byte_tx.sv
// serial_byte_tx: 1-start / 8-data (LSB first) / STOP_BITS-stop serial transmitter.
// A valid/ready byte input feeds the shifter directly when idle, and a one-entry
// holding buffer while busy, so consecutive frames leave with no idle gap.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   in_byte   byte to transmit, sampled only on a transfer
//   in_valid  in_byte is valid this cycle
//   in_ready  byte can be accepted this cycle (registered, !hold_full)
//   tx        serial line, registered, idles high
//   busy      a frame is in progress
//   done      one-cycle pulse after the last stop bit of a frame
module serial_byte_tx #(
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned SC_W  = (STOP_BITS  > 1) ? $clog2(STOP_BITS)  : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e           state_q,     state_d;
  logic [CYC_W-1:0] cyc_q,       cyc_d;
  logic [2:0]       bitcnt_q,    bitcnt_d;
  logic [SC_W-1:0]  stopcnt_q,   stopcnt_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       hold_q,      hold_d;
  logic             hold_full_q, hold_full_d;
  logic             in_ready_q,  in_ready_d;
  logic             tx_q,        tx_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  logic             xfer;
  logic             bit_end;
  logic             direct_load;

  assign xfer    = in_valid && in_ready_q;
  assign bit_end = (cyc_q == CYC_W'(BIT_CYCLES - 1));

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      bitcnt_q    <= '0;
      stopcnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      in_ready_q  <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bitcnt_q    <= bitcnt_d;
      stopcnt_q   <= stopcnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      in_ready_q  <= in_ready_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bitcnt_d    = bitcnt_q;
    stopcnt_d   = stopcnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    done_d      = 1'b0;
    direct_load = 1'b0;

    // Per-bit cycle counter free-runs while a frame is active
    if (state_q != ST_IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + CYC_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          shift_d     = in_byte;
          cyc_d       = '0;
          state_d     = ST_START;
          direct_load = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bitcnt_q == 3'd7) begin
            state_d   = ST_STOP;
            stopcnt_d = '0;
          end else begin
            shift_d  = {1'b0, shift_q[7:1]};
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stopcnt_q == SC_W'(STOP_BITS - 1)) begin
            done_d    = 1'b1;
            stopcnt_d = '0;
            if (hold_full_q) begin
              // Held byte goes out next; a same-edge transfer refills the buffer below
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              state_d     = ST_START;
            end else if (xfer) begin
              shift_d     = in_byte;
              state_d     = ST_START;
              direct_load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stopcnt_d = stopcnt_q + SC_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Transfers not consumed by the shifter land in the holding buffer
    if (xfer && !direct_load) begin
      hold_d      = in_byte;
      hold_full_d = 1'b1;
    end

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase

    busy_d     = (state_d != ST_IDLE);
    in_ready_d = !hold_full_d;
  end

  assign in_ready = in_ready_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Directed bench for serial_byte_tx: default instance (a_*) and a
// BIT_CYCLES=4 / STOP_BITS=2 instance (b_*). Line activity is logged per
// cycle and compared against hand-built frame vectors.
module tb_serial_byte_tx;

  localparam int unsigned LOGN = 2048;

  logic       clk;
  logic       reset_n;
  logic [7:0] a_in_byte, b_in_byte;
  logic       a_in_valid, b_in_valid;
  logic       a_in_ready, b_in_ready;
  logic       a_tx, b_tx, a_busy, b_busy, a_done, b_done;

  serial_byte_tx dut_a (
    .clk(clk), .reset_n(reset_n), .in_byte(a_in_byte), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .tx(a_tx), .busy(a_busy), .done(a_done)
  );

  serial_byte_tx #(.BIT_CYCLES(4), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_byte(b_in_byte), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .tx(b_tx), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle N = the interval after the N-th rising edge
  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic a_tx_log [LOGN];
  logic a_done_log [LOGN];
  logic a_busy_log [LOGN];
  logic a_rdy_log [LOGN];
  logic b_tx_log [LOGN];
  logic b_done_log [LOGN];
  logic b_busy_log [LOGN];

  always @(negedge clk) begin
    if (cyc_n < LOGN) begin
      a_tx_log[cyc_n]   <= a_tx;
      a_done_log[cyc_n] <= a_done;
      a_busy_log[cyc_n] <= a_busy;
      a_rdy_log[cyc_n]  <= a_in_ready;
      b_tx_log[cyc_n]   <= b_tx;
      b_done_log[cyc_n] <= b_done;
      b_busy_log[cyc_n] <= b_busy;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a byte to instance A until accepted; returns the accepting cycle. in_valid left high.
  task automatic send_a(input logic [7:0] b, output int unsigned n);
    logic r;
    logic ok;
    ok = 1'b0;
    n  = 0;
    a_in_byte  = b;
    a_in_valid = 1'b1;
    for (int g = 0; g < 64; g++) begin
      r = a_in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        n  = cyc_n;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_a_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_b(input logic [7:0] b, output int unsigned n);
    logic r;
    logic ok;
    ok = 1'b0;
    n  = 0;
    b_in_byte  = b;
    b_in_valid = 1'b1;
    for (int g = 0; g < 64; g++) begin
      r = b_in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        n  = cyc_n;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("send_b_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Expected 10-bit default frame, index 0 = start bit
  function automatic logic [9:0] frame10(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Count done pulses of instance A in [from, to)
  function automatic int count_done_a(input int unsigned from, input int unsigned to);
    int c;
    c = 0;
    for (int unsigned i = from; i < to; i++) if (a_done_log[i] === 1'b1) c++;
    return c;
  endfunction

  // Bench-side one-bit-per-clock receiver over instance A's logged line
  logic [7:0] rx_q [$];
  int         rx_ferr;
  task automatic decode_a(input int unsigned from, input int unsigned to);
    int unsigned p;
    logic [7:0]  by;
    rx_q.delete();
    rx_ferr = 0;
    p = from;
    while (p + 9 < to) begin
      if (a_tx_log[p] === 1'b0) begin
        for (int i = 0; i < 8; i++) by[i] = a_tx_log[p + 1 + i];
        if (a_tx_log[p + 9] !== 1'b1) rx_ferr++;
        rx_q.push_back(by);
        p = p + 10;
      end else begin
        p = p + 1;
      end
    end
  endtask

  logic [63:0] ov, ev;
  int unsigned n, m, k;
  logic [7:0]  bb;

  initial begin
    reset_n    = 1'b1;
    a_in_byte  = '0;
    a_in_valid = 1'b0;
    b_in_byte  = '0;
    b_in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_tx", 64'(a_tx), 64'd1);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_ready", 64'(a_in_ready), 64'd0);
    check("rst_b_tx", 64'(b_tx), 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 64'(a_in_ready), 64'd1);
    check("post_rst_b_ready", 64'(b_in_ready), 64'd1);
    wait_cycles(2);

    // Single frame 0xA5
    send_a(8'hA5, n);
    a_in_valid = 1'b0;
    wait_cycles(16);
    ov = '0;
    for (int i = 0; i < 10; i++) ov[i] = a_tx_log[n + i];
    check("a5_frame", ov, 64'(frame10(8'hA5)));
    check("a5_done_at_end", 64'(a_done_log[n + 10]), 64'd1);
    check("a5_done_count", 64'(count_done_a(n, n + 15)), 64'd1);
    check("a5_busy_last", 64'(a_busy_log[n + 9]), 64'd1);
    check("a5_busy_after", 64'(a_busy_log[n + 10]), 64'd0);
    ov = '0;
    for (int i = 0; i < 4; i++) ov[i] = a_tx_log[n + 10 + i];
    check("a5_idle_line", ov, 64'hF);

    // Back-to-back 0x00 then 0xFF with in_valid held high
    send_a(8'h00, n);
    send_a(8'hFF, m);
    a_in_valid = 1'b0;
    check("b2b_second_accept", 64'(m), 64'(n + 1));
    wait_cycles(24);
    check("b2b_ready_drop", 64'(a_rdy_log[m]), 64'd0);
    check("b2b_ready_held", 64'(a_rdy_log[n + 9]), 64'd0);
    check("b2b_ready_release", 64'(a_rdy_log[n + 10]), 64'd1);
    ov = '0;
    for (int i = 0; i < 20; i++) ov[i] = a_tx_log[n + i];
    ev = 64'({frame10(8'hFF), frame10(8'h00)});
    check("b2b_line", ov, ev);
    check("b2b_done1", 64'(a_done_log[n + 10]), 64'd1);
    check("b2b_done2", 64'(a_done_log[n + 20]), 64'd1);
    check("b2b_done_count", 64'(count_done_a(n, n + 24)), 64'd2);
    ov = '0;
    for (int i = 0; i < 20; i++) ov[i] = a_busy_log[n + i];
    check("b2b_busy", ov, 64'hF_FFFF);

    // Loopback: three bytes streamed back-to-back
    send_a(8'h12, n);
    send_a(8'h34, m);
    send_a(8'h56, m);
    a_in_valid = 1'b0;
    wait_cycles(30);
    decode_a(n, n + 40);
    check("loop_count", 64'(rx_q.size()), 64'd3);
    check("loop_ferr", 64'(rx_ferr), 64'd0);
    if (rx_q.size() == 3) begin
      check("loop_b0", 64'(rx_q[0]), 64'h12);
      check("loop_b1", 64'(rx_q[1]), 64'h34);
      check("loop_b2", 64'(rx_q[2]), 64'h56);
    end
    check("loop_done_count", 64'(count_done_a(n, n + 40)), 64'd3);

    // in_valid toggled with junk while in_ready=0
    send_a(8'h11, n);
    send_a(8'h22, m);
    a_in_byte = 8'h99;
    for (int i = 0; i < 7; i++) begin
      a_in_valid = (i % 2 == 0) && !a_in_ready;
      @(posedge clk);
      #1;
    end
    a_in_valid = 1'b0;
    wait_cycles(30);
    decode_a(n, n + 36);
    check("tog_count", 64'(rx_q.size()), 64'd2);
    if (rx_q.size() == 2) begin
      check("tog_b0", 64'(rx_q[0]), 64'h11);
      check("tog_b1", 64'(rx_q[1]), 64'h22);
    end
    check("tog_done_count", 64'(count_done_a(n, n + 36)), 64'd2);

    // Reset mid-DATA of 0x81 with 0x5A held
    send_a(8'h81, n);
    send_a(8'h5A, m);
    a_in_valid = 1'b0;
    wait_cycles(3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx", 64'(a_tx), 64'd1);
    check("mid_rst_ready", 64'(a_in_ready), 64'd0);
    check("mid_rst_busy", 64'(a_busy), 64'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_ready_hold", 64'(a_in_ready), 64'd0);
    reset_n = 1'b1;
    wait_cycles(30);
    k = 0;
    for (int unsigned i = n + 5; i < n + 35; i++) begin
      if (a_tx_log[i] !== 1'b1 || a_done_log[i] !== 1'b0 || a_busy_log[i] !== 1'b0) k++;
    end
    check("mid_rst_quiet", 64'(k), 64'd0);
    check("mid_rst_ready_after", 64'(a_in_ready), 64'd1);

    // BIT_CYCLES=4, STOP_BITS=2 frame of 0x3C
    send_b(8'h3C, n);
    b_in_valid = 1'b0;
    wait_cycles(56);
    bb = 8'h3C;
    ev = '0;
    for (int kk = 0; kk < 11; kk++) begin
      for (int j = 0; j < 4; j++) begin
        ev[kk * 4 + j] = (kk == 0) ? 1'b0 : (kk <= 8) ? bb[kk - 1] : 1'b1;
      end
    end
    ov = '0;
    for (int i = 0; i < 44; i++) ov[i] = b_tx_log[n + i];
    check("slow_frame", ov, ev);
    check("slow_done_at_end", 64'(b_done_log[n + 44]), 64'd1);
    k = 0;
    for (int unsigned i = n; i < n + 55; i++) if (b_done_log[i] === 1'b1) k++;
    check("slow_done_count", 64'(k), 64'd1);
    check("slow_busy_last", 64'(b_busy_log[n + 43]), 64'd1);
    check("slow_busy_after", 64'(b_busy_log[n + 44]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
